// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, expiry pulse and optional auto-reload
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load,
    input  logic             loaden,
    input  logic             clken,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] countout,
    output logic             zero,
    output logic             running,
    output logic             done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             zero_q, zero_d;

    // Next state: loaden beats stop beats start beats counting; stop also masks start
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        zero_d   = 1'b0;
        if (loaden) begin
            reload_d = load;
            count_d  = load;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = (start && !stop && count_q != '0) ? RUN : IDLE;
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (clken && count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (clken && count_q == WIDTH'(1)) begin
                        zero_d  = 1'b1;
                        count_d = AUTO_RELOAD ? reload_q : '0;
                        state_d = AUTO_RELOAD ? RUN : DONE;
                    end
                end
                PAUSE: state_d = (start && !stop) ? RUN : PAUSE;
                default: begin
                    if (start && !stop && reload_q != '0) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    // State registers, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            zero_q   <= zero_d;
        end
    end

    assign countout = count_q;
    assign zero     = zero_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
endmodule
